// File: rtl/adder_pkg.sv
// Shared definitions for the chunked add/subtract unit.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, the CHUNK-divides-WIDTH legality check and
// the helper that sizes the slice index counter.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A legal configuration has a positive CHUNK that evenly tiles WIDTH.
  function automatic bit chunk_fits(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  // Index width for a counter over n values, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// CHUNK-bit ripple-carry adder built from full-adder cells.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   i_a, i_b  CHUNK-bit operand slices
//   i_ci      carry into bit 0
//   o_s       CHUNK-bit sum slice
//   o_co      carry out of bit CHUNK-1
module slice_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co
);

  // The carry is walked through a procedural variable so the chain stays
  // one combinational process rather than a self-referencing vector.
  always_comb begin
    logic w_c;
    o_s  = '0;
    w_c  = i_ci;
    for (int i = 0; i < CHUNK; i++) begin
      o_s[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c    = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co = w_c;
  end

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits per clock.
// Latency: start accepted at edge 0, done pulses between edges N and N+1 (N = WIDTH/CHUNK).
// Backpressure: ready is high only in IDLE; start is ignored while busy.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, sub, ci      operation request, subtract select, add carry-in
//   a, b                WIDTH-bit operands, captured with start
//   ready, done         idle indication, one-cycle result-valid pulse
//   s, co, ov, zero     result, MSB carry-out, signed overflow, result==0
module chunked_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = idx_bits(N);

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("chunked_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;
  logic               r_ov;
  logic               r_zero;

  logic [CHUNK-1:0]   w_sum;
  logic               w_cout;
  logic               w_last;
  logic [WIDTH-1:0]   w_s_next;
  logic               w_c_into_msb;

  // Operands are shifted right every RUN cycle, so the active slice is
  // always the low CHUNK bits; one adder instance serves every slice.
  slice_adder #(
    .CHUNK (CHUNK)
  ) u_slice (
    .i_a  (r_a[CHUNK-1:0]),
    .i_b  (r_b[CHUNK-1:0]),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_cout)
  );

  assign w_last = (r_idx == IDX_W'(N - 1));

  // Result fills from the top: after N shifts slice 0 lands in the LSBs.
  assign w_s_next = (r_s >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));

  // On the last slice the operand MSBs sit at bit CHUNK-1; the carry into
  // the MSB is recovered from the full-adder sum identity.
  assign w_c_into_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready = (r_state == ST_IDLE);
    done  = (r_state == ST_DONE);
    s     = r_s;
    co    = r_co;
    ov    = r_ov;
    zero  = r_zero;
  end

  // Datapath. Subtract is folded into the captured operand (b inverted) and
  // the carry seed (forced to 1), so no separate op flag is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : ci;
            r_idx   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
            r_zero  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_cout;
          r_s     <= w_s_next;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_co   <= w_cout;
            r_ov   <= w_cout ^ w_c_into_msb;
            r_zero <= (w_s_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
module tb_chunked_addsub;

  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         ci = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ov;
  logic         zero;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         zero;
  } res_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .ci    (ci),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .s     (s),
    .co    (co),
    .ov    (ov),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic op, input logic cin);
    res_t         r;
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   t;
    yy     = op ? ~y : y;
    c0     = op ? 1'b1 : cin;
    t      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c0};
    r.s    = t[W-1:0];
    r.co   = t[W];
    r.ov   = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  // One operation; optionally re-pulses start with different operands at
  // edges 3 and 8, which must not disturb the result.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic op, input logic cin, input bit repulse);
    int   lat;
    int   pulses;
    res_t at_done;
    res_t e;
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(ready), 64'(1));
    a = x; b = y; sub = op; ci = cin; start = 1'b1;
    sb_q.push_back(model(x, y, op, cin));
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    pulses = 0;
    at_done = '0;
    for (int k = 1; k <= 12; k++) begin
      if (repulse && (k == 3 || k == 8)) begin
        a = ~x; b = x ^ y; sub = ~op; ci = ~cin; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          at_done = {s, co, ov, zero};
        end
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(N));
    check({tag, "_done_pulses"}, 64'(pulses), 64'(1));
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'(1));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_result_at_done"}, 64'(at_done), 64'(e));
      check({tag, "_result_held"}, 64'({s, co, ov, zero}), 64'(e));
    end
    check({tag, "_ready_after"}, 64'(ready), 64'(1));
  endtask

  initial begin
    int pulses;
    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_outputs", 64'({done, s, co, ov, zero}), 64'(0));

    // Release just after an edge so the very next edge samples start.
    @(posedge clk);
    #1 rst_n = 1'b1;

    do_op("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op("sub_neg",   32'd5,         32'd7,         1'b1, 1'b0, 1'b0);
    do_op("sub_pos",   32'd7,         32'd5,         1'b1, 1'b0, 1'b0);
    do_op("add_ci",    32'd0,         32'd0,         1'b0, 1'b1, 1'b0);
    do_op("sub_ci_ig", 32'd0,         32'd0,         1'b1, 1'b1, 1'b0);
    do_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    do_op("repulse",   32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_op("random", 32'($urandom), 32'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; ci = 1'b1; start = 1'b1;
    sb_q.push_back(model(a, b, sub, ci));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'(1));
    check("midrst_outputs", 64'({done, s, co, ov, zero}), 64'(0));
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'(0));
    check("midrst_idle", 64'(ready), 64'(1));

    do_op("post_rst", 32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 1'b0);
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
